stream_mux_arb: RTL
===================

# stream_mux_arb

Parametrised N-channel stream multiplexer with valid/ready handshakes, selectable arbitration mode and a registered output stage. It is the sequential successor of the 4-bit 4:1 combinational mux. It merges N producer streams onto one consumer stream, either under explicit select control (fixed mode) or by fair round-robin arbitration. It sits between multiple producer blocks and a single shared consumer or bus.

## Interface
Parameters:
- `N_CH`, default 4: number of input channels; legal range is 2 or more.
- `W`, default 4: data width in bits.
- `SEL_W`, default `$clog2(N_CH)`: width of the select and channel-ID fields; derived, not overridden.

Ports:
- `clk` input, 1 bit: sole clock, rising edge.
- `rst_n` input, 1 bit: asynchronous assert, active-low reset.
- `mode` input, 1 bit: `0` = FIXED, `1` = RR (round-robin); values come from the package enum.
- `sel` input, `SEL_W` bits: channel to pass through in FIXED mode; ignored in RR mode.
- `in_valid` input, `N_CH` bits: per-channel valid.
- `in_data` input, `N_CH` × `W` bits: per-channel data, packed array with channel 0 in the LSBs.
- `in_ready` output, `N_CH` bits: per-channel ready; at most one bit is high in any cycle.
- `out_valid` output, 1 bit: output beat held in the register.
- `out_data` output, `W` bits: output beat data.
- `out_chan` output, `SEL_W` bits: source channel of the current output beat.
- `out_ready` input, 1 bit: consumer ready.

## Operation
- Output stage is a one-entry register holding `out_valid`, `out_data` and `out_chan`.
- `load = !out_valid || out_ready`, so the stage can accept a new beat in the same cycle the consumer drains the old one.
- Grant is combinational and one-hot (`grant[N_CH-1:0]`). `in_ready = load ? grant : 0`.
- A transfer on channel i occurs when `in_valid[i] && in_ready[i]`. At the next edge the register captures `in_data[i]`, sets `out_chan = i` and sets `out_valid = 1`.
- If `load` is true and there is no grant: when `out_ready` is high, `out_valid` goes to 0; `out_data` and `out_chan` hold their values.
- FIXED mode:
  - `grant[sel] = in_valid[sel]`; all other grant bits are 0.
  - If `sel >= N_CH`, there is no grant.
- RR mode:
  - A pointer `ptr` (`SEL_W` bits) names the highest-priority channel.
  - The search runs `ptr, ptr+1, …, N_CH-1, 0, …, ptr-1` and grants the first channel with `in_valid` set.
  - On a transfer from channel g, `ptr` becomes `(g+1) mod N_CH`. Wrap is explicit, so `N_CH` need not be a power of two.
  - `ptr` is unchanged in cycles with no transfer, and is unchanged by FIXED-mode transfers.
- Mode or `sel` changes take effect in the same cycle's grant. A beat already in the output register is never altered.
- `in_valid` may drop without a transfer; the arbiter re-evaluates every cycle, so there is no lock-in.
- Reset (`rst_n` low, asynchronous): `out_valid = 0`, `out_data = 0`, `out_chan = 0`, `ptr = 0`. `in_ready` is forced to 0 while `rst_n` is low. Reset mid-stream drops the held beat.

## Timing
- Latency is 1 cycle from an input handshake to `out_valid`/`out_data`.
- Throughput is 1 beat per cycle with `out_ready` held high.
- `in_ready` depends combinationally on `in_valid`, `mode`, `sel`, `ptr`, `out_valid` and `out_ready`.
- The output side is fully registered, with no combinational path from inputs to `out_*`.
- Backpressure: while `out_valid && !out_ready`, all `out_*` signals are stable and `in_ready` is 0.
- Simultaneous drain and fill in one cycle: `out_ready = 1` together with an input transfer yields back-to-back beats with no bubble.

## Structure
- Package `stream_mux_pkg`: `typedef enum logic {MODE_FIXED, MODE_RR} mux_mode_t;` and a `function automatic` for round-robin next-pointer wrap.
- Sub-module `rr_arbiter`:
  - Parameter: `N_CH`.
  - Inputs: `clk`, `rst_n`, `req[N_CH]`, `en`, `advance`.
  - Outputs: `grant[N_CH]` (one-hot) and `grant_idx`.
  - Holds `ptr` internally.
- Top level contains the mode mux for grant, the `in_ready` gating, the data select (one-hot AND-OR) and the output register.

## Test plan
- Reset: hold `rst_n = 0` with `in_valid = 4'hF`. Required: `out_valid = 0`, `out_data = 0`, `out_chan = 0`, `in_ready = 0`. After release with `out_ready = 1` in RR mode, the first beat is from ch0.
- FIXED, `sel = 2`, all channels valid, data `{D,C,B,A}`, `out_ready = 1`:
  - `in_ready = 4'b0100` every cycle.
  - Starting 1 cycle later, `out_data = 4'hC` and `out_chan = 2` every cycle.
  - `ptr` stays 0.
- RR, `in_valid = 4'hF` held, `out_ready = 1`: `out_chan` sequence is `0,1,2,3,0,1`, one beat per cycle with no bubbles.
- RR, `in_valid = 4'b1010`: `out_chan` sequence is `1,3,1,3`. Then drop ch3, i.e. `in_valid = 4'b0010`: only ch1 is granted, every cycle.
- Backpressure: with a beat held, pull `out_ready = 0` for 3 cycles. Required: `out_*` stable and `in_ready = 0` throughout. Raise `out_ready`: the next beat appears in the following cycle.
- `N_CH = 3`, FIXED, `sel = 3`, all channels valid: `in_ready = 0` and `out_valid` falls to 0 after draining. Then switch to RR mid-stream: grants resume from the stored `ptr` and wrap `2 → 0`.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg
// Shared types and helpers for the stream multiplexer/arbiter.
//   mux_mode_t : arbitration mode select (fixed select or round-robin)
//   rr_next    : round-robin pointer successor with explicit wrap, so the
//                channel count does not need to be a power of two

package stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n_ch);
        return (idx + 1 >= n_ch) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter with an internal priority pointer.
// Ports:
//   clk, rst_n  : clock, async active-low reset (ptr returns to 0)
//   req         : per-channel request
//   en          : arbiter active; when low no grant is produced
//   advance     : a transfer happened on grant; ptr moves past the winner
//   grant       : one-hot grant
//   grant_idx   : index of the granted channel (0 when no grant)

module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  req,
    input  logic             en,
    input  logic             advance,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] cand_idx;
    logic             found;
    int               cand;

    // Search ptr, ptr+1, ... with wrap; the first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N_CH) begin
                cand = cand - N_CH;
            end
            cand_idx = SEL_W'(cand);
            if (en && !found && req[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
                found           = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = SEL_W'(rr_next(int'(grant_idx), N_CH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// stream_mux_arb
// N-channel valid/ready stream multiplexer with a one-entry registered
// output stage. Channel choice is either an explicit select (FIXED) or
// fair round-robin (RR).
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   mode                : MODE_FIXED / MODE_RR
//   sel                 : channel passed through in FIXED mode
//   in_valid/in_data    : producer streams, channel 0 in the LSBs
//   in_ready            : per-channel ready, at most one bit high
//   out_valid/out_data  : registered output beat
//   out_chan            : source channel of the output beat
//   out_ready           : consumer ready

module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W     = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  mux_mode_t              mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_CH-1:0]        in_valid,
    input  logic [N_CH-1:0][W-1:0] in_data,
    output logic [N_CH-1:0]        in_ready,
    output logic                   out_valid,
    output logic [W-1:0]           out_data,
    output logic [SEL_W-1:0]       out_chan,
    input  logic                   out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;

    logic [N_CH-1:0]  grant_fix, grant_rr, grant;
    logic [SEL_W-1:0] rr_idx;
    logic [W-1:0]     data_sel;
    logic [SEL_W-1:0] chan_sel;
    logic             load, xfer;

    assign load = !out_valid_q || out_ready;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .en        (mode == MODE_RR),
        .advance   ((mode == MODE_RR) && xfer),
        .grant     (grant_rr),
        .grant_idx (rr_idx)
    );

    // Out-of-range select grants nothing.
    always_comb begin
        grant_fix = '0;
        if (int'(sel) < N_CH) begin
            grant_fix[sel] = in_valid[sel];
        end
    end

    assign grant = (mode == MODE_RR) ? grant_rr : grant_fix;

    // The reset term keeps in_ready low while rst_n is held, even though
    // the empty output stage would otherwise report load.
    assign in_ready = (rst_n && load) ? grant : '0;
    assign xfer     = |in_ready;

    // One-hot AND-OR select; rr_idx is unused because the same encode
    // serves both modes.
    always_comb begin
        data_sel = '0;
        chan_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            data_sel = data_sel | ({W{grant[i]}} & in_data[i]);
            if (grant[i]) begin
                chan_sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = data_sel;
            out_chan_d  = chan_sel;
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

    logic unused_rr_idx;
    assign unused_rr_idx = ^rr_idx;

endmodule
